// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: copies the image ROM into video RAM and shares the
// single RAM write port with a host writer using slot reservation.
module vram_fill_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int ROM_AW   = 12,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 1,
  parameter int FILL_LEN = 2048,
  parameter int ROM_BASE = 0
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_ad,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              wr_ce,
  output logic [ADDR_W-1:0] wr_ad,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FILL_LEN - 1);
  localparam logic [ROM_AW-1:0] BASE =
    ROM_AW'(ROM_BASE);
  localparam logic [ROM_LAT-1:0] HEAD =
    ROM_LAT'(1) << (ROM_LAT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_i;
  logic [ROM_AW-1:0]   r_rom_ad;
  logic                r_busy;
  logic                r_done;
  logic                r_hstarve;
  logic [ROM_LAT-1:0]  r_v;
  logic [ADDR_W-1:0]   r_tag [ROM_LAT];
  logic                r_wr_ce;
  logic [ADDR_W-1:0]   r_wr_ad;
  logic [DATA_W-1:0]   r_wr_data;

  logic w_arrive;
  logic w_accept;
  logic w_issue;
  logic w_rest_empty;

  assign w_arrive     = r_v[ROM_LAT-1];
  assign host_ready   = rst && !w_arrive;
  assign w_accept     = host_valid && host_ready;
  assign w_issue      = (r_state == S_FILL) && !r_hstarve;
  // Only the word arriving now (if any) is still outstanding.
  assign w_rest_empty = (r_v & ~HEAD) == '0;

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_rom_ad <= BASE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FILL;
            r_busy   <= 1'b1;
            r_i      <= '0;
            r_rom_ad <= BASE;
          end
        end
        S_FILL: begin
          if (w_issue) begin
            r_i      <= r_i + 1'b1;
            r_rom_ad <= r_rom_ad + 1'b1;
            if (r_i == LAST)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_rest_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int k = 0; k < ROM_LAT; k++)
        r_tag[k] <= '0;
    end else begin
      r_v[0]   <= w_issue;
      r_tag[0] <= r_i;
      for (int k = 1; k < ROM_LAT; k++) begin
        r_v[k]   <= r_v[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // A host blocked by a copy slot reserves the next free slot.
  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst)
      r_hstarve <= 1'b0;
    else if (host_valid && w_arrive)
      r_hstarve <= 1'b1;
    else if (w_accept)
      r_hstarve <= 1'b0;
  end

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ce   <= 1'b0;
      r_wr_ad   <= '0;
      r_wr_data <= '0;
    end else begin
      unique case (1'b1)
        w_arrive: begin
          r_wr_ce   <= 1'b1;
          r_wr_ad   <= r_tag[ROM_LAT-1];
          r_wr_data <= rom_data;
        end
        w_accept: begin
          r_wr_ce   <= 1'b1;
          r_wr_ad   <= host_ad;
          r_wr_data <= host_data;
        end
        default: r_wr_ce <= 1'b0;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rom_ad  = r_rom_ad;
  assign wr_ce   = r_wr_ce;
  assign wr_ad   = r_wr_ad;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// tb_vram_fill_arbiter: three configurations driven with shared random
// stimulus; the selected one is compared against a queue-based model.
module tb_vram_fill_arbiter;

  localparam int LAT_T  [3] = '{1, 2, 3};
  localparam int FL_T   [3] = '{8, 8, 4};
  localparam int BASE_T [3] = '{0, 0, 'hFFE};

  logic write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  logic        rst;
  logic        start;
  logic        hv;
  logic [10:0] had;
  logic [7:0]  hd;

  logic        busy [3];
  logic        done [3];
  logic        host_ready [3];
  logic        wr_ce [3];
  logic [11:0] rom_ad [3];
  logic [7:0]  rom_data [3];
  logic [7:0]  wr_data [3];
  logic [10:0] wr_ad [3];
  logic [11:0] rp [3][4];

  vram_fill_arbiter #(
    .ROM_LAT(1), .FILL_LEN(8), .ROM_BASE(0)
  ) u_dut0 (
    .write_clk(write_clk), .rst(rst), .start(start),
    .busy(busy[0]), .done(done[0]), .rom_ad(rom_ad[0]),
    .rom_data(rom_data[0]), .host_valid(hv), .host_ad(had),
    .host_data(hd), .host_ready(host_ready[0]),
    .wr_ce(wr_ce[0]), .wr_ad(wr_ad[0]), .wr_data(wr_data[0])
  );

  vram_fill_arbiter #(
    .ROM_LAT(2), .FILL_LEN(8), .ROM_BASE(0)
  ) u_dut1 (
    .write_clk(write_clk), .rst(rst), .start(start),
    .busy(busy[1]), .done(done[1]), .rom_ad(rom_ad[1]),
    .rom_data(rom_data[1]), .host_valid(hv), .host_ad(had),
    .host_data(hd), .host_ready(host_ready[1]),
    .wr_ce(wr_ce[1]), .wr_ad(wr_ad[1]), .wr_data(wr_data[1])
  );

  vram_fill_arbiter #(
    .ROM_LAT(3), .FILL_LEN(4), .ROM_BASE('hFFE)
  ) u_dut2 (
    .write_clk(write_clk), .rst(rst), .start(start),
    .busy(busy[2]), .done(done[2]), .rom_ad(rom_ad[2]),
    .rom_data(rom_data[2]), .host_valid(hv), .host_ad(had),
    .host_data(hd), .host_ready(host_ready[2]),
    .wr_ce(wr_ce[2]), .wr_ad(wr_ad[2]), .wr_data(wr_data[2])
  );

  function automatic logic [7:0] romf(input logic [11:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge write_clk)
    for (int n = 0; n < 3; n++) begin
      rp[n][0] <= rom_ad[n];
      for (int k = 1; k < 4; k++)
        rp[n][k] <= rp[n][k-1];
    end

  always_comb
    for (int n = 0; n < 3; n++)
      rom_data[n] = romf(rp[n][LAT_T[n]-1]);

  int n_cmp, n_bad;
  int sel, L, FL, e, start_e, stall_cnt, hwait, dcnt;
  logic [11:0] m_base;
  int          m_st, m_i;
  bit          m_starve, m_ce, m_done, m_busy;
  bit          m_acc, m_arr, hr_prev;
  logic [10:0] m_ad;
  logic [7:0]  m_data;
  logic [11:0] m_rom;
  logic [31:0] cmask;
  int          q_e[$];
  int          q_t[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d cfg %0d)",
               tag, got, exp, e, sel);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_i = 0; m_starve = 0;
    m_ce = 0; m_done = 0; m_busy = 0;
    m_ad = '0; m_data = '0; m_rom = m_base;
    q_e.delete(); q_t.delete();
  endtask

  // One edge of the reference behaviour, from the inputs at that edge.
  task automatic m_step();
    m_arr = q_e.size() > 0 && q_e[0] == e;
    m_acc = hv && !m_arr;
    m_done = 1'b0;
    if (m_arr) begin
      m_ce   = 1'b1;
      m_ad   = 11'(q_t[0]);
      m_data = romf(m_base + 12'(q_t[0]));
      void'(q_e.pop_front());
      void'(q_t.pop_front());
    end else if (m_acc) begin
      m_ce = 1'b1; m_ad = had; m_data = hd;
    end else begin
      m_ce = 1'b0;
    end
    case (m_st)
      0: if (start) begin
        m_st = 1; m_busy = 1; m_i = 0; m_rom = m_base;
        start_e = e; stall_cnt = 0; cmask = '0;
      end
      1: if (m_starve) stall_cnt++;
        else begin
          q_e.push_back(e + L);
          q_t.push_back(m_i);
          m_i++;
          m_rom = m_base + 12'(m_i);
          if (m_i == FL) m_st = 2;
        end
      default: if (q_e.size() == 0) begin
        m_done = 1; m_busy = 0; m_st = 0;
      end
    endcase
    if (hv && m_arr) m_starve = 1;
    else if (m_acc) m_starve = 0;
  endtask

  task automatic tick();
    bit acc_dut;
    bit nxt_arr;
    @(posedge write_clk); #1;
    e++;
    acc_dut = hv && hr_prev;
    m_step();
    chk("busy",    32'(busy[sel]),    32'(m_busy));
    chk("done",    32'(done[sel]),    32'(m_done));
    chk("wr_ce",   32'(wr_ce[sel]),   32'(m_ce));
    chk("wr_ad",   32'(wr_ad[sel]),   32'(m_ad));
    chk("wr_data", 32'(wr_data[sel]), 32'(m_data));
    chk("rom_ad",  32'(rom_ad[sel]),  32'(m_rom));
    if (hv) begin
      if (acc_dut) begin
        chk("host_wait", 32'(hwait <= L + 1), 32'd1);
        hwait = 0;
      end else begin
        hwait++;
      end
    end
    if (m_arr && wr_ce[sel])
      cmask |= 32'd1 << wr_ad[sel];
    if (done[sel]) begin
      dcnt++;
      chk("done_lat", 32'(e - start_e), 32'(FL + L + stall_cnt));
      chk("copy_mask", cmask, (32'd1 << FL) - 32'd1);
    end
    nxt_arr = q_e.size() > 0 && q_e[0] == e + 1;
    hr_prev = host_ready[sel];
    chk("host_ready", 32'(hr_prev), 32'(!nxt_arr));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  32'(busy[sel]),       32'd0);
    chk({tag, "_done"},  32'(done[sel]),       32'd0);
    chk({tag, "_ce"},    32'(wr_ce[sel]),      32'd0);
    chk({tag, "_ad"},    32'(wr_ad[sel]),      32'd0);
    chk({tag, "_data"},  32'(wr_data[sel]),    32'd0);
    chk({tag, "_rom"},   32'(rom_ad[sel]),     32'(m_base));
    chk({tag, "_ready"}, 32'(host_ready[sel]), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; #1;
    m_reset();
    chk_reset("rst_async");
    @(posedge write_clk); #1;
    e++;
    chk_reset("rst_hold");
    rst = 1'b1; #1;
    hwait = 0;
    hr_prev = host_ready[sel];
    chk("rdy_after_rst", 32'(hr_prev), 32'd1);
  endtask

  task automatic new_req();
    had = 11'($urandom);
    hd  = 8'($urandom);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; e = 0; dcnt = 0; hwait = 0;
    start_e = 0; stall_cnt = 0; cmask = '0; hr_prev = 0;
    rst = 1'b0; start = 1'b0; hv = 1'b0; had = '0; hd = '0;
    for (int s = 0; s < 3; s++) begin
      sel = s; L = LAT_T[s]; FL = FL_T[s];
      m_base = 12'(BASE_T[s]);
      hv = 1'b0; start = 1'b0;
      #3;
      do_reset();

      dcnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      chk("done_once", 32'(dcnt), 32'd1);

      if (s == 0) begin
        hv = 1'b1; had = 11'h123; hd = 8'h5A;
        chk("idle_ready", 32'(host_ready[sel]), 32'd1);
        tick();
        chk("idle_ce",   32'(wr_ce[sel]),   32'd1);
        chk("idle_ad",   32'(wr_ad[sel]),   32'h123);
        chk("idle_data", 32'(wr_data[sel]), 32'h5A);
        hv = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        do_reset();
        repeat (5) tick();
        dcnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        chk("fill_after_rst", 32'(dcnt), 32'd1);
      end

      dcnt = 0;
      hv = 1'b1; new_req();
      start = 1'b1;
      for (int c = 0; c < 60; c++) begin
        tick();
        start = 1'b0;
        chk("stream_ce", 32'(wr_ce[sel]), 32'd1);
        if (m_acc) new_req();
      end
      chk("stream_done_once", 32'(dcnt), 32'd1);
      for (int c = 0; c < 10 && hv; c++) begin
        tick();
        if (m_acc) hv = 1'b0;
      end

      for (int c = 0; c < 300; c++) begin
        start = ($urandom_range(0, 7) == 0);
        if (!hv) begin
          if ($urandom_range(0, 2) == 0) begin
            hv = 1'b1; new_req();
          end
        end else if (m_acc) begin
          if ($urandom_range(0, 1) == 0) hv = 1'b0;
          else new_req();
        end
        tick();
      end
      start = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
